// File: rtl/ifetch_prefetch_unit.sv
// Instruction prefetch unit: issues word reads to a 1-cycle-latency IMEM and
// queues the returned words with their PCs for decode behind a valid/ready handshake.
module ifetch_prefetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] IMEM_addr_o,
   output logic        IMEM_read_n_o,
   input  logic [31:0] IMEM_data_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   input  logic        instr_ready_i
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   logic [31:0]   fetch_pc;
   logic          inflight;
   logic [31:0]   inflight_pc;
   logic [31:0]   fifo_pc   [FIFO_DEPTH];
   logic [31:0]   fifo_word [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic issue;
   logic push;
   logic pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credit counts the in-flight word, so a push can never land in a full buffer;
   // reset_n gates the request so the port is idle while held in reset.
   assign issue = reset_n && !redirect_i
                  && ((32'(count) + 32'(inflight)) < FIFO_DEPTH);
   assign push  = inflight && !redirect_i;
   assign pop   = instr_valid_o && instr_ready_i && !redirect_i;

   assign IMEM_addr_o   = fetch_pc;
   assign IMEM_read_n_o = !issue;
   assign instr_valid_o = (count != '0);
   assign instr_o       = instr_valid_o ? fifo_word[rd_ptr] : '0;
   assign instr_pc_o    = instr_valid_o ? fifo_pc[rd_ptr]   : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else if (redirect_i) begin
         fetch_pc <= redirect_pc_i & ~32'h3;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
         end
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         assert (count != CW'(FIFO_DEPTH))
            else $error("push into full instruction buffer");
         fifo_pc[wr_ptr]   <= inflight_pc;
         fifo_word[wr_ptr] <= IMEM_data_i;
      end
   end

endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// Directed bench for ifetch_prefetch_unit: IMEM model returns 0x1000_0000 + word
// index one cycle after each request; decode-side outputs checked at negedges.
module tb_ifetch_prefetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] imem_addr;
   logic        imem_read_n;
   logic [31:0] imem_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   int errors = 0;
   int checks = 0;

   ifetch_prefetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .FIFO_DEPTH(4)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .IMEM_addr_o  (imem_addr),
      .IMEM_read_n_o(imem_read_n),
      .IMEM_data_i  (imem_data),
      .redirect_i   (redirect),
      .redirect_pc_i(redirect_pc),
      .instr_valid_o(instr_valid),
      .instr_o      (instr),
      .instr_pc_o   (instr_pc),
      .instr_ready_i(instr_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!imem_read_n) imem_data <= 32'h1000_0000 + (imem_addr >> 2);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
   endtask

   task automatic expect_head(input string tag, input logic [31:0] pc);
      chk({tag, " valid"}, {31'd0, instr_valid}, 32'd1);
      chk({tag, " pc"}, instr_pc, pc);
      chk({tag, " instr"}, instr, 32'h1000_0000 + (pc >> 2));
   endtask

   task automatic expect_empty(input string tag);
      chk({tag, " valid"}, {31'd0, instr_valid}, 32'd0);
      chk({tag, " instr"}, instr, 32'd0);
      chk({tag, " pc"}, instr_pc, 32'd0);
   endtask

   task automatic do_redirect(input string tag, input logic [31:0] pc);
      redirect    = 1'b1;
      redirect_pc = pc;
      #1 chk({tag, " no req in redirect"}, {31'd0, imem_read_n}, 32'd1);
      @(negedge clk);
      redirect = 1'b0;
      #1;
      expect_empty({tag, " flushed"});
   endtask

   initial begin
      reset_n     = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      instr_ready = 1'b1;
      imem_data   = '0;

      // Reset state
      @(negedge clk);
      chk("rst addr", imem_addr, 32'h0);
      chk("rst read_n", {31'd0, imem_read_n}, 32'd1);
      expect_empty("rst");

      // 1: start-up latency and steady streaming
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("t1 first addr", imem_addr, 32'h0);
      chk("t1 first read_n", {31'd0, imem_read_n}, 32'd0);
      @(negedge clk);
      chk("t1 lat valid", {31'd0, instr_valid}, 32'd0);
      chk("t1 second addr", imem_addr, 32'h4);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         expect_head("t1 stream", 32'(k) * 4);
      end

      // 2: stalled decode fills exactly FIFO_DEPTH entries, then drains in order
      do_redirect("t2", 32'h0);
      instr_ready = 1'b0;
      repeat (10) @(negedge clk);
      expect_head("t2 held", 32'h0);
      chk("t2 read_n stalled", {31'd0, imem_read_n}, 32'd1);
      chk("t2 addr stalled", imem_addr, 32'h10);
      instr_ready = 1'b1;
      for (int k = 1; k < 6; k++) begin
         @(negedge clk);
         expect_head("t2 drain", 32'(k) * 4);
      end

      // 3: redirect with 3 buffered entries and a read in flight
      instr_ready = 1'b0;
      @(negedge clk);
      expect_head("t3 pre", 32'h14);
      do_redirect("t3", 32'h0000_0103);
      chk("t3 addr", imem_addr, 32'h100);
      chk("t3 read_n", {31'd0, imem_read_n}, 32'd0);
      instr_ready = 1'b1;
      @(negedge clk);
      chk("t3 lat valid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
      expect_head("t3 first", 32'h100);
      @(negedge clk);
      expect_head("t3 second", 32'h104);

      // 4: redirect coincides with valid && ready
      do_redirect("t4", 32'h0000_0200);
      chk("t4 addr", imem_addr, 32'h200);
      @(negedge clk);
      chk("t4 lat valid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
      expect_head("t4 first", 32'h200);

      // 5: PC wraps past the top of the address space
      do_redirect("t5", 32'hFFFF_FFF8);
      @(negedge clk);
      @(negedge clk);
      expect_head("t5 a", 32'hFFFF_FFF8);
      @(negedge clk);
      expect_head("t5 b", 32'hFFFF_FFFC);
      @(negedge clk);
      expect_head("t5 wrap", 32'h0000_0000);

      // 6: asynchronous reset mid-stream with a read in flight
      @(negedge clk);
      expect_head("t6 pre", 32'h4);
      reset_n = 1'b0;
      #1;
      chk("t6 rst addr", imem_addr, 32'h0);
      chk("t6 rst read_n", {31'd0, imem_read_n}, 32'd1);
      expect_empty("t6 rst");
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("t6 restart addr", imem_addr, 32'h0);
      @(negedge clk);
      chk("t6 no stale", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
      expect_head("t6 first", 32'h0);
      @(negedge clk);
      expect_head("t6 second", 32'h4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
